id_scoreboard: RTL and testbench

Parametrised register scoreboard sitting beside the ID stage of the in-order LoongArch pipeline. It replaces the single hard-wired load-use check with per-register tracking of in-flight writes. Fixed-latency producers (ALU, load, multiplier) count down to forwardability; unknown-latency producers (divider) stay pending until writeback. ID gates `ds_ready_go` with `issue_ready` and pulses `issue_fire` on each accepted instruction.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/sb_entry.sv | 63 ++++++
 rtl/id_scoreboard.sv | 69 ++++++
 tb/tb_id_scoreboard.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the ID-stage scoreboard and its entries.
//   - Register-file geometry (NREG, AW, NSRC) and producer latency codes.
//   - LAT_UNK (all-ones) marks an unknown-latency producer such as the divider.
//   - src_field() extracts operand k from the packed source-index bus.
package cpu_pkg;

    localparam int unsigned CPU_NREG    = 32;
    localparam int unsigned CPU_AW      = 5;
    localparam int unsigned CPU_NSRC    = 3;
    localparam int unsigned CPU_MAX_LAT = 6;
    localparam int unsigned CPU_LW      = $clog2(CPU_MAX_LAT + 2);

    typedef logic [CPU_AW-1:0] reg_idx_t;
    typedef logic [CPU_LW-1:0] lat_t;

    localparam lat_t LAT_ALU  = lat_t'(0);
    localparam lat_t LAT_LOAD = lat_t'(1);
    localparam lat_t LAT_MUL  = lat_t'(2);
    localparam lat_t LAT_UNK  = '1;

    function automatic reg_idx_t src_field(input logic [CPU_NSRC*CPU_AW-1:0] bus,
                                           input int unsigned                 k);
        return bus[k*CPU_AW +: CPU_AW];
    endfunction

endpackage

// File: rtl/sb_entry.sv
// sb_entry: tracking state for one architectural register.
//   i_clk, i_resetn : clock, asynchronous active-low reset
//   i_flush         : discard all tracking at the edge
//   i_issue, i_lat  : a producer targeting this register issues with latency i_lat
//   i_wb            : unknown-latency writeback to this register
//   o_pend          : register still has an in-flight write
//   o_unk           : an unknown-latency producer is outstanding
module sb_entry #(
    parameter int unsigned LW = 3
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic          i_flush,
    input  logic          i_issue,
    input  logic [LW-1:0] i_lat,
    input  logic          i_wb,
    output logic          o_pend,
    output logic          o_unk
);

    localparam logic [LW-1:0] LatUnk = '1;

    logic [LW-1:0] r_cnt;
    logic          r_unk;
    logic [LW-1:0] w_cnt_d;
    logic          w_unk_d;

    // Priority: flush > issue > writeback > decrement.
    always_comb begin
        w_cnt_d = (r_cnt != '0) ? r_cnt - LW'(1) : '0;
        w_unk_d = r_unk;
        if (i_wb) begin
            w_unk_d = 1'b0;
        end
        if (i_issue) begin
            if (i_lat == LatUnk) begin
                w_cnt_d = '0;
                w_unk_d = 1'b1;
            end else begin
                w_cnt_d = i_lat;
                w_unk_d = 1'b0;
            end
        end
        if (i_flush) begin
            w_cnt_d = '0;
            w_unk_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cnt <= '0;
            r_unk <= 1'b0;
        end else begin
            r_cnt <= w_cnt_d;
            r_unk <= w_unk_d;
        end
    end

    assign o_pend = (r_cnt != '0) || r_unk;
    assign o_unk  = r_unk;

endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register RAW/WAW tracking beside the ID stage.
//   src_idx/src_en         : source operands of the instruction in ID
//   dst_we/dst_idx/dst_lat : its destination and producer latency (LAT_UNK = unknown)
//   issue_fire             : instruction accepted into EX this cycle
//   wb_valid/wb_idx        : unknown-latency producer writeback
//   flush                  : discard all in-flight tracking
//   src_hazard             : per-source RAW hazard
//   issue_ready            : no RAW or WAW hazard
//   pending_any            : some register still pending
module id_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned NREG    = CPU_NREG,
    parameter int unsigned AW      = CPU_AW,
    parameter int unsigned NSRC    = CPU_NSRC,
    parameter int unsigned MAX_LAT = CPU_MAX_LAT,
    parameter int unsigned LW      = $clog2(MAX_LAT + 2)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NSRC*AW-1:0] src_idx,
    input  logic [NSRC-1:0]    src_en,
    input  logic               dst_we,
    input  logic [AW-1:0]      dst_idx,
    input  logic [LW-1:0]      dst_lat,
    input  logic               issue_fire,
    input  logic               wb_valid,
    input  logic [AW-1:0]      wb_idx,
    input  logic               flush,
    output logic [NSRC-1:0]    src_hazard,
    output logic               issue_ready,
    output logic               pending_any
);

    logic [NREG-1:0] w_pend;
    logic [NREG-1:0] w_unk;
    logic [AW-1:0]   w_src_idx [NSRC];
    logic            w_waw;

    // r0 is hard-wired zero and never tracked.
    assign w_pend[0] = 1'b0;
    assign w_unk[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        sb_entry #(
            .LW (LW)
        ) u_ent (
            .i_clk    (clk),
            .i_resetn (resetn),
            .i_flush  (flush),
            .i_issue  (issue_fire && dst_we && (dst_idx == AW'(r))),
            .i_lat    (dst_lat),
            .i_wb     (wb_valid && (wb_idx == AW'(r))),
            .o_pend   (w_pend[r]),
            .o_unk    (w_unk[r])
        );
    end

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        assign w_src_idx[k]  = src_field(src_idx, k);
        assign src_hazard[k] = src_en[k] && (w_src_idx[k] != '0) && w_pend[w_src_idx[k]];
    end

    // An older divider writeback must not clear tracking of a newer write.
    assign w_waw       = dst_we && (dst_idx != '0) && w_unk[dst_idx];
    assign issue_ready = ~|src_hazard && !w_waw;
    assign pending_any = |w_pend;

endmodule

// File: tb/tb_id_scoreboard.sv
module tb_id_scoreboard;

    logic        clk = 1'b0;
    logic        resetn;
    logic [14:0] src_idx;
    logic [2:0]  src_en;
    logic        dst_we;
    logic [4:0]  dst_idx;
    logic [2:0]  dst_lat;
    logic        issue_fire;
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic        flush;
    logic [2:0]  src_hazard;
    logic        issue_ready;
    logic        pending_any;

    int total = 0;
    int bad   = 0;

    id_scoreboard dut (
        .clk         (clk),
        .resetn      (resetn),
        .src_idx     (src_idx),
        .src_en      (src_en),
        .dst_we      (dst_we),
        .dst_idx     (dst_idx),
        .dst_lat     (dst_lat),
        .issue_fire  (issue_fire),
        .wb_valid    (wb_valid),
        .wb_idx      (wb_idx),
        .flush       (flush),
        .src_hazard  (src_hazard),
        .issue_ready (issue_ready),
        .pending_any (pending_any)
    );

    always #5 clk = ~clk;

    // Reference model: each register has the cycle number from which its
    // result is forwardable, plus a flag for an outstanding unknown-latency write.
    int rdy_at [32];
    bit unk_m  [32];
    int cyc = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < 32; r++) begin
                rdy_at[r] = 0;
                unk_m[r]  = 1'b0;
            end
        end else begin
            cyc++;
            if (flush) begin
                for (int r = 0; r < 32; r++) begin
                    rdy_at[r] = 0;
                    unk_m[r]  = 1'b0;
                end
            end else begin
                if (wb_valid && wb_idx != 0) unk_m[wb_idx] = 1'b0;
                if (issue_fire && dst_we && dst_idx != 0) begin
                    if (dst_lat == 3'd7) begin
                        unk_m[dst_idx]  = 1'b1;
                        rdy_at[dst_idx] = 0;
                    end else begin
                        unk_m[dst_idx]  = 1'b0;
                        rdy_at[dst_idx] = cyc + int'(dst_lat);
                    end
                end
            end
        end
    end

    // Issuing into a hazard is a protocol violation.
    always @(posedge clk) begin
        if (resetn && issue_fire) begin
            total++;
            if (!issue_ready) begin
                bad++;
                $display("FAIL protocol: issue_fire while issue_ready=%0b at t=%0t",
                         issue_ready, $time);
            end
        end
    end

    function automatic bit m_pend(input int r);
        return (r != 0) && ((rdy_at[r] > cyc) || unk_m[r]);
    endfunction

    function automatic logic [2:0] m_haz();
        logic [2:0] h;
        for (int k = 0; k < 3; k++) begin
            h[k] = src_en[k] && m_pend(int'(src_idx[k*5 +: 5]));
        end
        return h;
    endfunction

    function automatic bit m_ready();
        return (m_haz() == 3'b000) && !(dst_we && dst_idx != 0 && unk_m[dst_idx]);
    endfunction

    function automatic bit m_pend_any();
        for (int r = 1; r < 32; r++) if (m_pend(r)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk3(input string name, input logic [2:0] h, input logic r, input logic p);
        chk({name, ".hazard"}, 32'(src_hazard), 32'(h));
        chk({name, ".ready"}, 32'(issue_ready), 32'(r));
        chk({name, ".pending"}, 32'(pending_any), 32'(p));
    endtask

    task automatic drive(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] sen, input logic dwe, input logic [4:0] didx,
                         input logic [2:0] dlat, input logic iss, input logic wbv,
                         input logic [4:0] wbi, input logic fl);
        src_idx    = {s2, s1, s0};
        src_en     = sen;
        dst_we     = dwe;
        dst_idx    = didx;
        dst_lat    = dlat;
        issue_fire = iss;
        wb_valid   = wbv;
        wb_idx     = wbi;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0] s0, s1, s2;
        logic [2:0] sen;
        logic       dwe;
        logic [4:0] didx;
        logic [2:0] dlat;
        logic       iss, wbv;
        logic [4:0] wbi;
        logic       fl;
        logic [2:0] haz;
        logic       rdy, pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] s0, s1, s2, input logic [2:0] sen,
                                input logic dwe, input logic [4:0] didx,
                                input logic [2:0] dlat, input logic iss, wbv,
                                input logic [4:0] wbi, input logic fl,
                                input logic [2:0] haz, input logic rdy, pend);
        vec_t v;
        v.s0 = s0; v.s1 = s1; v.s2 = s2; v.sen = sen; v.dwe = dwe; v.didx = didx;
        v.dlat = dlat; v.iss = iss; v.wbv = wbv; v.wbi = wbi; v.fl = fl;
        v.haz = haz; v.rdy = rdy; v.pend = pend;
        return v;
    endfunction

    initial begin
        //               s0 s1 s2 sen    we dst lat iss wb wbi fl  haz   rdy pend
        vecs.push_back(mk(5, 6, 7, 3'b111, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0));
        vecs.push_back(mk(1, 2, 3, 3'b111, 1, 4, 1, 1, 0, 0, 0, 3'b000, 1, 0)); // load r4
        vecs.push_back(mk(4, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 1)); // one stall
        vecs.push_back(mk(4, 0, 0, 3'b001, 1, 8, 0, 1, 0, 0, 0, 3'b000, 1, 0)); // alu r8
        vecs.push_back(mk(8, 0, 0, 3'b001, 1, 9, 2, 1, 0, 0, 0, 3'b000, 1, 0)); // mul r9
        vecs.push_back(mk(0, 0, 9, 3'b101, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 1));
        vecs.push_back(mk(0, 0, 9, 3'b101, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 1));
        vecs.push_back(mk(0, 0, 9, 3'b101, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 3'b000, 1, 12, 7, 1, 0, 0, 0, 3'b000, 1, 0)); // div r12
        vecs.push_back(mk(0, 12, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 1));
        vecs.push_back(mk(0, 0, 0, 3'b000, 1, 12, 0, 0, 0, 0, 0, 3'b000, 0, 1)); // WAW
        vecs.push_back(mk(0, 12, 0, 3'b010, 0, 0, 0, 0, 1, 12, 0, 3'b010, 0, 1)); // wb
        vecs.push_back(mk(0, 12, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 3'b000, 1, 3, 2, 1, 1, 3, 0, 3'b000, 1, 0)); // iss+wb r3
        vecs.push_back(mk(3, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 1));
        vecs.push_back(mk(0, 0, 0, 3'b000, 1, 3, 1, 1, 0, 0, 0, 3'b000, 1, 1)); // reload
        vecs.push_back(mk(3, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 1));
        vecs.push_back(mk(3, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 3'b000, 1, 10, 2, 1, 0, 0, 0, 3'b000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 3'b000, 1, 11, 7, 1, 0, 0, 0, 3'b000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 3'b000, 1, 13, 1, 1, 0, 0, 1, 3'b000, 1, 1)); // flush
        vecs.push_back(mk(10, 11, 13, 3'b111, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0));

        // Reset held with live sources.
        resetn = 1'b0;
        drive(5, 6, 7, 3'b111, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk3("reset_hold", 3'b000, 1'b1, 1'b0);
        #9 resetn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].sen, vecs[i].dwe, vecs[i].didx,
                  vecs[i].dlat, vecs[i].iss, vecs[i].wbv, vecs[i].wbi, vecs[i].fl);
            #1;
            chk3($sformatf("vec%0d", i), vecs[i].haz, vecs[i].rdy, vecs[i].pend);
            tick();
        end

        // Asynchronous reset in the middle of a countdown.
        drive(0, 0, 0, 3'b000, 1, 9, 6, 1, 0, 0, 0);
        tick();
        drive(0, 0, 9, 3'b100, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk3("cd_before", 3'b100, 1'b0, 1'b1);
        tick();
        #3 resetn = 1'b0;
        #1;
        chk3("async_reset", 3'b000, 1'b1, 1'b0);
        drive(5, 6, 7, 3'b111, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk3("reset_edge", 3'b000, 1'b1, 1'b0);
        #3 resetn = 1'b1;
        tick();

        // Divider stays pending until writeback; a new write to it is WAW-blocked.
        drive(0, 0, 0, 3'b000, 1, 12, 7, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 12, 0, 3'b010, 1, 12, 0, 0, 0, 0, 0);
            #1;
            chk3($sformatf("div_wait%0d", i), 3'b010, 1'b0, 1'b1);
            tick();
        end
        drive(0, 12, 0, 3'b010, 0, 0, 0, 0, 1, 12, 0);
        #1;
        chk3("div_wb", 3'b010, 1'b0, 1'b1);
        tick();
        drive(0, 12, 0, 3'b010, 1, 12, 0, 0, 0, 0, 0);
        #1;
        chk3("div_done", 3'b000, 1'b1, 1'b0);
        tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] lat;
            case ($urandom_range(0, 5))
                0: lat = 3'd0;
                1: lat = 3'd1;
                2: lat = 3'd2;
                3: lat = 3'd3;
                4: lat = 3'd6;
                default: lat = 3'd7;
            endcase
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), lat, 1'b0,
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 49) == 0));
            issue_fire = m_ready() && ($urandom_range(0, 3) != 0);
            #1;
            chk3($sformatf("rnd%0d", i), m_haz(), m_ready(), m_pend_any());
            tick();
        end

        drive(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
